// File: rtl/tag_store_pkg.sv
// Shared types for the N-way tag store: controller states, stored entry
// layout and small helpers used by the top and the way banks.
package tag_store_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Entries carry the widest supported tag; unused upper bits stay zero.
  localparam int unsigned MAX_TAG_WIDTH = 32;

  typedef struct packed {
    logic                     valid;
    logic [MAX_TAG_WIDTH-1:0] tag;
  } entry_t;

  function automatic entry_t make_entry(input logic                     valid,
                                        input logic [MAX_TAG_WIDTH-1:0] tag);
    entry_t e;
    e.valid = valid;
    e.tag   = tag;
    return e;
  endfunction

  // True when more than one bit of v is set (v & (v-1) clears the lowest one).
  function automatic logic more_than_one(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/tag_way_bank.sv
// One way of the tag store: a flop array of {valid, tag} entries with a single
// write port and a registered read port (one-cycle read latency).
module tag_way_bank
  import tag_store_pkg::*;
#(
  parameter int unsigned SET_ID_WIDTH = 5,
  parameter int unsigned TAG_WIDTH    = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [SET_ID_WIDTH-1:0] waddr,
  input  logic                    wvalid,
  input  logic [TAG_WIDTH-1:0]    wtag,
  input  logic                    re,
  input  logic [SET_ID_WIDTH-1:0] raddr,
  output logic                    rvalid,
  output logic [TAG_WIDTH-1:0]    rtag
);

  localparam int unsigned NB_SETS = 2 ** SET_ID_WIDTH;

  entry_t                   mem [NB_SETS];
  entry_t                   rd_q;
  logic [MAX_TAG_WIDTH-1:0] unused_tag;

  // Storage is intentionally not reset; the controller's sweep invalidates it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= make_entry(wvalid, MAX_TAG_WIDTH'(wtag));
    end
    if (re) begin
      rd_q <= mem[raddr];
    end
  end

  assign rvalid     = rd_q.valid;
  assign rtag       = rd_q.tag[TAG_WIDTH-1:0];
  assign unused_tag = rd_q.tag;

endmodule

// File: rtl/tag_store_nway.sv
// N-way set-associative tag store with per-way hit detection, sticky
// multi-hit flag and an invalidate-all sweep on reset and on flush request.
module tag_store_nway
  import tag_store_pkg::*;
#(
  parameter int unsigned NB_WAYS      = 4,
  parameter int unsigned SET_ID_WIDTH = 5,
  parameter int unsigned TAG_WIDTH    = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_i,
  output logic                         gnt_o,
  input  logic                         write_i,
  input  logic [SET_ID_WIDTH-1:0]      addr_i,
  input  logic [NB_WAYS-1:0]           wway_i,
  input  logic [TAG_WIDTH-1:0]         wtag_i,
  input  logic                         wvalid_i,
  input  logic [TAG_WIDTH-1:0]         cmp_tag_i,
  output logic                         rvalid_o,
  output logic [NB_WAYS*TAG_WIDTH-1:0] rtag_o,
  output logic [NB_WAYS-1:0]           rvld_o,
  output logic [NB_WAYS-1:0]           hit_way_o,
  output logic                         hit_o,
  output logic                         multi_hit_o,
  input  logic                         flush_req_i,
  output logic                         flush_ack_o,
  output logic                         busy_o
);

  localparam logic [SET_ID_WIDTH-1:0] LAST_SET = '1;

  state_e                   state_q, state_d;
  logic [SET_ID_WIDTH-1:0]  cnt_q, cnt_d;
  logic                     sweep;
  logic                     accept, rd_acc, wr_acc;
  logic [SET_ID_WIDTH-1:0]  bank_addr;
  logic                     bank_wvalid;
  logic [TAG_WIDTH-1:0]     bank_wtag;
  logic                     rvalid_q;
  logic [TAG_WIDTH-1:0]     cmp_tag_q;
  logic                     multi_q;
  logic [7:0]               hit_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The ack is a Moore output of the last sweep cycle so a requester that
  // drops flush_req_i on seeing it avoids a second sweep.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sweep       = 1'b0;
    gnt_o       = 1'b0;
    flush_ack_o = 1'b0;
    case (state_q)
      INIT: begin
        sweep = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        sweep = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) begin
          state_d     = IDLE;
          flush_ack_o = 1'b1;
        end
      end
      IDLE: begin
        if (flush_req_i) begin
          state_d = FLUSH;
        end else begin
          gnt_o = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  assign accept      = req_i & gnt_o;
  assign rd_acc      = accept & ~write_i;
  assign wr_acc      = accept & write_i;
  assign bank_addr   = sweep ? cnt_q : addr_i;
  assign bank_wvalid = sweep ? 1'b0 : wvalid_i;
  assign bank_wtag   = sweep ? '0 : wtag_i;

  for (genvar w = 0; w < NB_WAYS; w++) begin : g_way
    tag_way_bank #(
      .SET_ID_WIDTH(SET_ID_WIDTH),
      .TAG_WIDTH   (TAG_WIDTH)
    ) u_bank (
      .clk   (clk),
      .we    (sweep | (wr_acc & wway_i[w])),
      .waddr (bank_addr),
      .wvalid(bank_wvalid),
      .wtag  (bank_wtag),
      .re    (rd_acc),
      .raddr (addr_i),
      .rvalid(rvld_o[w]),
      .rtag  (rtag_o[w*TAG_WIDTH +: TAG_WIDTH])
    );

    assign hit_way_o[w] = rvalid_q & rvld_o[w] &
                          (rtag_o[w*TAG_WIDTH +: TAG_WIDTH] == cmp_tag_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q  <= 1'b0;
      cmp_tag_q <= '0;
      multi_q   <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        cmp_tag_q <= cmp_tag_i;
      end
      if (more_than_one(hit_ext)) begin
        multi_q <= 1'b1;
      end
    end
  end

  assign rvalid_o    = rvalid_q;
  assign hit_o       = |hit_way_o;
  assign hit_ext     = 8'(hit_way_o);
  // Flag is visible on the offending response cycle and held thereafter.
  assign multi_hit_o = multi_q | more_than_one(hit_ext);

endmodule

// File: tb/tb_tag_store_nway.sv
// Self-checking bench for tag_store_nway: directed scenarios plus a randomized
// access stream checked against an array-based model of the tag store.
module tb_tag_store_nway;

  localparam int NW    = 4;
  localparam int SW    = 5;
  localparam int TW    = 10;
  localparam int NSETS = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_i, write_i, wvalid_i, flush_req_i;
  logic [SW-1:0]      addr_i;
  logic [NW-1:0]      wway_i;
  logic [TW-1:0]      wtag_i, cmp_tag_i;
  logic               gnt_o, rvalid_o, hit_o, multi_hit_o, flush_ack_o, busy_o;
  logic [NW*TW-1:0]   rtag_o;
  logic [NW-1:0]      rvld_o, hit_way_o;

  int errors = 0;
  int checks = 0;

  logic          m_vld [NSETS][NW];
  logic [TW-1:0] m_tag [NSETS][NW];
  logic          m_multi;

  always #5 clk = ~clk;

  tag_store_nway #(
    .NB_WAYS     (NW),
    .SET_ID_WIDTH(SW),
    .TAG_WIDTH   (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .write_i    (write_i),
    .addr_i     (addr_i),
    .wway_i     (wway_i),
    .wtag_i     (wtag_i),
    .wvalid_i   (wvalid_i),
    .cmp_tag_i  (cmp_tag_i),
    .rvalid_o   (rvalid_o),
    .rtag_o     (rtag_o),
    .rvld_o     (rvld_o),
    .hit_way_o  (hit_way_o),
    .hit_o      (hit_o),
    .multi_hit_o(multi_hit_o),
    .flush_req_i(flush_req_i),
    .flush_ack_o(flush_ack_o),
    .busy_o     (busy_o)
  );

  // ---------------- reference model ----------------
  function automatic logic [NW-1:0] exp_rvld(input int a);
    logic [NW-1:0] r;
    for (int w = 0; w < NW; w++) r[w] = m_vld[a][w];
    return r;
  endfunction

  function automatic logic [NW*TW-1:0] exp_rtag(input int a);
    logic [NW*TW-1:0] r;
    for (int w = 0; w < NW; w++) r[w*TW +: TW] = m_tag[a][w];
    return r;
  endfunction

  // Tags of invalid entries are unspecified, so only valid ways are compared.
  function automatic logic [NW*TW-1:0] tag_mask(input logic [NW-1:0] v);
    logic [NW*TW-1:0] r;
    for (int w = 0; w < NW; w++) r[w*TW +: TW] = v[w] ? '1 : '0;
    return r;
  endfunction

  function automatic logic [NW-1:0] exp_hit(input int a, input logic [TW-1:0] cmp);
    logic [NW-1:0] r;
    for (int w = 0; w < NW; w++) r[w] = m_vld[a][w] && (m_tag[a][w] == cmp);
    return r;
  endfunction

  function automatic int popc(input logic [NW-1:0] v);
    int n = 0;
    for (int w = 0; w < NW; w++) n += int'(v[w]);
    return n;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NW; w++) m_vld[s][w] = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_i = 0; write_i = 0; flush_req_i = 0; wvalid_i = 0;
    addr_i = '0; wway_i = '0; wtag_i = '0; cmp_tag_i = '0;
  endtask

  task automatic do_write(input int a, input logic [NW-1:0] way,
                          input logic [TW-1:0] tag, input logic v);
    req_i = 1; write_i = 1; addr_i = SW'(a); wway_i = way; wtag_i = tag; wvalid_i = v;
    step();
    for (int w = 0; w < NW; w++)
      if (way[w]) begin m_vld[a][w] = v; m_tag[a][w] = tag; end
    drive_idle();
  endtask

  task automatic do_read(input int a, input logic [TW-1:0] cmp);
    req_i = 1; write_i = 0; addr_i = SW'(a); cmp_tag_i = cmp;
    step();
    drive_idle();
  endtask

  task automatic wait_init(output int n, output int acks);
    n = 0; acks = 0;
    while (busy_o === 1'b1 && n < 100) begin
      n++;
      if (flush_ack_o === 1'b1) acks++;
      step();
    end
  endtask

  task automatic sweep_until_ack(output int n, output bit seen);
    n = 0; seen = 0;
    while (n < 100) begin
      n++;
      if (flush_ack_o === 1'b1) begin seen = 1; break; end
      step();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n, acks;
    drive_idle();
    rst = 1;
    repeat (3) step();
    checks++;
    if (gnt_o !== 0 || busy_o !== 1 || rvalid_o !== 0 || flush_ack_o !== 0 || multi_hit_o !== 0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b busy=%b rvalid=%b ack=%b multi=%b, want 0 1 0 0 0",
               gnt_o, busy_o, rvalid_o, flush_ack_o, multi_hit_o);
    end
    rst = 0;
    model_clear();
    m_multi = 0;
    wait_init(n, acks);
    checks++;
    if (n !== 32) begin errors++; $display("FAIL init_busy_cycles: got %0d want 32", n); end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL init_no_ack: got %0d acks want 0", acks); end
    checks++;
    if (gnt_o !== 1 || busy_o !== 0) begin
      errors++; $display("FAIL init_to_idle: gnt=%b busy=%b want 1 0", gnt_o, busy_o);
    end
    do_read($urandom_range(0, NSETS-1), TW'($urandom));
    checks++;
    if (rvalid_o !== 1 || rvld_o !== 4'b0000 || hit_way_o !== 4'b0000) begin
      errors++; $display("FAIL init_all_invalid: rvalid=%b rvld=%b hit=%b want 1 0000 0000",
                         rvalid_o, rvld_o, hit_way_o);
    end
  endtask

  task automatic test_write_read();
    do_write(3, 4'b0100, 10'h2A5, 1);
    do_read(3, 10'h2A5);
    checks++;
    if (rvalid_o !== 1 || rvld_o !== exp_rvld(3)) begin
      errors++; $display("FAIL wr_rd_valid: rvalid=%b rvld=%b want 1 %b", rvalid_o, rvld_o, exp_rvld(3));
    end
    checks++;
    if (rtag_o[2*TW +: TW] !== 10'h2A5) begin
      errors++; $display("FAIL wr_rd_tag: got %h want 2a5", rtag_o[2*TW +: TW]);
    end
    checks++;
    if (hit_way_o !== 4'b0100 || hit_o !== 1) begin
      errors++; $display("FAIL wr_rd_hit: hit_way=%b hit=%b want 0100 1", hit_way_o, hit_o);
    end
    step();
    checks++;
    if (rvalid_o !== 0 || hit_way_o !== 0 || hit_o !== 0) begin
      errors++; $display("FAIL resp_one_cycle: rvalid=%b hit_way=%b hit=%b want 0 0000 0",
                         rvalid_o, hit_way_o, hit_o);
    end
  endtask

  task automatic test_wway_zero();
    req_i = 1; write_i = 1; addr_i = 5'd3; wway_i = '0; wtag_i = 10'h3FF; wvalid_i = 1;
    #1;
    checks++;
    if (gnt_o !== 1) begin errors++; $display("FAIL wway0_gnt: got %b want 1", gnt_o); end
    step();
    drive_idle();
    checks++;
    if (rvalid_o !== 0) begin errors++; $display("FAIL wway0_no_resp: rvalid=%b want 0", rvalid_o); end
    do_read(3, 10'h2A5);
    checks++;
    if (rvld_o !== exp_rvld(3) || hit_way_o !== exp_hit(3, 10'h2A5)) begin
      errors++; $display("FAIL wway0_unchanged: rvld=%b hit=%b want %b %b",
                         rvld_o, hit_way_o, exp_rvld(3), exp_hit(3, 10'h2A5));
    end
  endtask

  task automatic test_multi_hit();
    checks++;
    if (multi_hit_o !== 0) begin errors++; $display("FAIL multi_initial: got %b want 0", multi_hit_o); end
    do_write(7, 4'b0011, 10'h011, 1);
    do_read(7, 10'h011);
    m_multi = m_multi | (popc(exp_hit(7, 10'h011)) > 1);
    checks++;
    if (hit_way_o !== 4'b0011 || multi_hit_o !== 1) begin
      errors++; $display("FAIL multi_set: hit_way=%b multi=%b want 0011 1", hit_way_o, multi_hit_o);
    end
    do_read(3, 10'h2A5);
    repeat (3) step();
    checks++;
    if (multi_hit_o !== 1) begin errors++; $display("FAIL multi_sticky: got %b want 1", multi_hit_o); end
  endtask

  task automatic test_flush();
    int n;
    bit seen;
    do_write(0, 4'b0001, 10'h101, 1);
    do_write(0, 4'b0010, 10'h102, 1);
    do_write(0, 4'b0100, 10'h103, 1);
    do_write(0, 4'b1000, 10'h104, 1);
    do_read(0, 10'h103);
    checks++;
    if (rvld_o !== 4'b1111 || hit_way_o !== 4'b0100) begin
      errors++; $display("FAIL flush_prefill: rvld=%b hit=%b want 1111 0100", rvld_o, hit_way_o);
    end
    flush_req_i = 1; req_i = 1; write_i = 0; addr_i = '0; cmp_tag_i = 10'h101;
    #1;
    checks++;
    if (gnt_o !== 0) begin errors++; $display("FAIL flush_priority_gnt: got %b want 0", gnt_o); end
    step();
    drive_idle();
    checks++;
    if (rvalid_o !== 0 || busy_o !== 1) begin
      errors++; $display("FAIL flush_enter: rvalid=%b busy=%b want 0 1", rvalid_o, busy_o);
    end
    sweep_until_ack(n, seen);
    checks++;
    if (!seen || n !== 32) begin
      errors++; $display("FAIL flush_ack_timing: seen=%0d cycles=%0d want 1 32", seen, n);
    end
    step();
    model_clear();
    checks++;
    if (flush_ack_o !== 0 || busy_o !== 0 || gnt_o !== 1 || multi_hit_o !== m_multi) begin
      errors++; $display("FAIL flush_exit: ack=%b busy=%b gnt=%b multi=%b want 0 0 1 %b",
                         flush_ack_o, busy_o, gnt_o, multi_hit_o, m_multi);
    end
    do_read(0, 10'h101);
    checks++;
    if (rvalid_o !== 1 || rvld_o !== 4'b0000 || hit_o !== 0) begin
      errors++; $display("FAIL flush_invalid: rvalid=%b rvld=%b hit=%b want 1 0000 0", rvalid_o, rvld_o, hit_o);
    end
  endtask

  task automatic test_read_before_flush();
    int n;
    bit seen;
    do_write(5, 4'b0010, 10'h155, 1);
    req_i = 1; write_i = 0; addr_i = 5'd5; cmp_tag_i = 10'h155;
    step();
    drive_idle();
    flush_req_i = 1;
    checks++;
    if (rvalid_o !== 1 || rvld_o !== 4'b0010 || hit_way_o !== 4'b0010 || rtag_o[TW +: TW] !== 10'h155) begin
      errors++; $display("FAIL read_before_flush: rvalid=%b rvld=%b hit=%b tag1=%h want 1 0010 0010 155",
                         rvalid_o, rvld_o, hit_way_o, rtag_o[TW +: TW]);
    end
    step();
    flush_req_i = 0;
    sweep_until_ack(n, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL rbf_ack_timeout: cycles=%0d", n); end
    step();
    model_clear();
  endtask

  task automatic test_reset_mid_read();
    int n, acks;
    do_write(9, 4'b1000, 10'h0F0, 1);
    req_i = 1; write_i = 0; addr_i = 5'd9; cmp_tag_i = 10'h0F0;
    step();
    drive_idle();
    rst = 1;
    #1;
    checks++;
    if (rvalid_o !== 0 || hit_o !== 0 || hit_way_o !== 0 || multi_hit_o !== 0 || busy_o !== 1) begin
      errors++; $display("FAIL reset_mid_read: rvalid=%b hit=%b hit_way=%b multi=%b busy=%b want 0 0 0000 0 1",
                         rvalid_o, hit_o, hit_way_o, multi_hit_o, busy_o);
    end
    step();
    rst = 0;
    model_clear();
    m_multi = 0;
    wait_init(n, acks);
    checks++;
    if (n !== 32 || acks !== 0) begin
      errors++; $display("FAIL reinit_after_read: cycles=%0d acks=%0d want 32 0", n, acks);
    end
  endtask

  task automatic test_reset_mid_flush();
    int n, acks, early;
    flush_req_i = 1;
    step();
    flush_req_i = 0;
    early = 0;
    for (int i = 0; i < 10; i++) begin
      if (flush_ack_o === 1'b1) early++;
      step();
    end
    rst = 1;
    #1;
    checks++;
    if (flush_ack_o !== 0 || busy_o !== 1 || gnt_o !== 0 || early !== 0) begin
      errors++; $display("FAIL reset_mid_flush: ack=%b busy=%b gnt=%b early_acks=%0d want 0 1 0 0",
                         flush_ack_o, busy_o, gnt_o, early);
    end
    step();
    rst = 0;
    model_clear();
    m_multi = 0;
    wait_init(n, acks);
    checks++;
    if (n !== 32 || acks !== 0) begin
      errors++; $display("FAIL reinit_after_flush: cycles=%0d acks=%0d want 32 0", n, acks);
    end
  endtask

  task automatic test_random();
    logic [TW-1:0] pool [4];
    bit            pend;
    int            pa;
    logic [TW-1:0] pc;
    logic [NW-1:0] ev, eh;
    logic [NW*TW-1:0] et, mk;
    pool[0] = 10'h2A5; pool[1] = 10'h011; pool[2] = 10'h3FF; pool[3] = 10'h000;
    pend = 0; pa = 0; pc = '0;
    for (int i = 0; i < 400; i++) begin
      if (pend) begin
        ev = exp_rvld(pa); eh = exp_hit(pa, pc); et = exp_rtag(pa); mk = tag_mask(ev);
        m_multi = m_multi | (popc(eh) > 1);
        checks++;
        if (rvalid_o !== 1 || rvld_o !== ev || hit_way_o !== eh || hit_o !== (|eh)) begin
          errors++; $display("FAIL rand_resp[%0d]: rvalid=%b rvld=%b hit=%b hit_o=%b want 1 %b %b %b",
                             i, rvalid_o, rvld_o, hit_way_o, hit_o, ev, eh, |eh);
        end
        checks++;
        if ((rtag_o & mk) !== (et & mk)) begin
          errors++; $display("FAIL rand_tags[%0d]: got %h want %h", i, rtag_o & mk, et & mk);
        end
      end else begin
        checks++;
        if (rvalid_o !== 0 || hit_way_o !== 0 || hit_o !== 0) begin
          errors++; $display("FAIL rand_quiet[%0d]: rvalid=%b hit=%b hit_o=%b want 0 0000 0",
                             i, rvalid_o, hit_way_o, hit_o);
        end
      end
      checks++;
      if (multi_hit_o !== m_multi) begin
        errors++; $display("FAIL rand_multi[%0d]: got %b want %b", i, multi_hit_o, m_multi);
      end
      req_i     = ($urandom_range(0, 3) != 0);
      write_i   = $urandom_range(0, 1);
      addr_i    = SW'($urandom_range(0, 3));
      wway_i    = NW'($urandom_range(0, 15));
      wtag_i    = pool[$urandom_range(0, 3)];
      wvalid_i  = ($urandom_range(0, 3) != 0);
      cmp_tag_i = pool[$urandom_range(0, 3)];
      #1;
      checks++;
      if (gnt_o !== 1) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want 1", i, gnt_o); end
      pend = req_i && !write_i;
      pa = int'(addr_i);
      pc = cmp_tag_i;
      if (req_i && write_i)
        for (int w = 0; w < NW; w++)
          if (wway_i[w]) begin m_vld[pa][w] = wvalid_i; m_tag[pa][w] = wtag_i; end
      step();
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wway_zero();
    test_multi_hit();
    test_flush();
    test_read_before_flush();
    test_reset_mid_read();
    test_reset_mid_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tag_store_nway.md
TAG_STORE_NWAY -- requirements
Module: tag_store_nway

Interface
REQ-001 Parameter NB_WAYS, default 4: number of ways; legal range 1..8.
REQ-002 Parameter SET_ID_WIDTH, default 5: set address width; the block holds 2**SET_ID_WIDTH sets.
REQ-003 Parameter TAG_WIDTH, default 10: tag width, excluding the valid bit.
REQ-004 clk  in  1  single clock; all state is updated on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_i  in  1  access request, level.
REQ-007 gnt_o  out  1  grant; an access is accepted in a cycle where req_i and gnt_o are both high.
REQ-008 write_i  in  1  1 = write, 0 = read/lookup.
REQ-009 addr_i  in  SET_ID_WIDTH  set index.
REQ-010 wway_i  in  NB_WAYS  one-hot write-way select; ignored on reads.
REQ-011 wtag_i  in  TAG_WIDTH  tag to write.
REQ-012 wvalid_i  in  1  valid bit to write; 0 invalidates the entry.
REQ-013 cmp_tag_i  in  TAG_WIDTH  lookup tag, sampled on read acceptance.
REQ-014 rvalid_o  out  1  read-response strobe.
REQ-015 rtag_o  out  NB_WAYS*TAG_WIDTH  tags of all ways; way w occupies bits [w*TAG_WIDTH +: TAG_WIDTH].
REQ-016 rvld_o  out  NB_WAYS  per-way valid bits.
REQ-017 hit_way_o  out  NB_WAYS  per-way hit: valid AND tag equal to cmp_tag_i.
REQ-018 hit_o  out  1  OR-reduction of hit_way_o.
REQ-019 multi_hit_o  out  1  sticky error flag: more than one hit_way_o bit was high on a response.
REQ-020 flush_req_i  in  1  invalidate-all request, level.
REQ-021 flush_ack_o  out  1  one-cycle pulse on flush completion.
REQ-022 busy_o  out  1  high while a sweep is in progress.

Function
REQ-023 FSM states SHALL be INIT, IDLE, FLUSH; rst forces INIT.
REQ-024 INIT and FLUSH: a sweep counter runs from 0 to 2**SET_ID_WIDTH-1, one set per cycle, writing valid=0 to all ways of that set; gnt_o=0 and busy_o=1 throughout.
REQ-025 Counter at its last value: INIT goes to IDLE with no ack; FLUSH goes to IDLE with flush_ack_o=1 on the same edge; the counter wraps to 0.
REQ-026 IDLE: gnt_o=1 unless flush_req_i=1.
  - flush_req_i=1 moves the FSM to FLUSH on the next edge; flush takes priority over a same-cycle req_i, which is not granted.
REQ-027 flush_req_i held high after flush_ack_o starts another sweep; the requester deasserts it on the ack.
REQ-028 Accepted write: wtag_i/wvalid_i are stored into every way selected by wway_i at addr_i on that edge; no response is produced (rvalid_o stays 0).
REQ-029 Accepted read: rvalid_o, rtag_o, rvld_o, hit_way_o, hit_o SHALL be valid exactly one cycle later; latency 1, back-to-back reads sustain one per cycle.
REQ-030 A read accepted the cycle after a write to the same set SHALL return the newly written data; no extra latency, no stale data.
REQ-031 hit_way_o is computed from the registered cmp_tag_i and the read data; it is combinational on the response cycle only.
  - When rvalid_o=0, hit_way_o, hit_o and rvalid_o SHALL be 0.
REQ-032 multi_hit_o SHALL set on any response with popcount(hit_way_o)>1 and clear only on rst.
REQ-033 A read accepted in the cycle before the FSM enters FLUSH SHALL still respond, with pre-flush contents.
REQ-034 wway_i=0 on a write: no-op, still granted.

Reset
REQ-035 On rst: gnt_o=0, rvalid_o=0, flush_ack_o=0, multi_hit_o=0, busy_o=1, FSM=INIT, counter=0, registered cmp tag=0.
REQ-036 Tag storage contents are not reset; the INIT sweep establishes all-invalid state.
REQ-037 rst asserted mid-sweep or mid-read SHALL abort the operation; no ack and no response follow.

Structure
REQ-038 Shared package tag_store_pkg SHALL hold the FSM state enum (INIT, IDLE, FLUSH) and the entry struct {valid, tag}.
REQ-039 One sub-module tag_way_bank: a single-way 1R/1W latch/flop array with 1-cycle read; instantiated NB_WAYS times by generate.

Verification
REQ-040 Reset, then cycle count: NB_WAYS=4, SET_ID_WIDTH=5 -> busy_o=1 and gnt_o=0 for exactly 32 cycles; flush_ack_o never pulses; any read afterwards gives rvld_o=4'b0000.
REQ-041 Write set 3 way 2, tag 0x2A5, valid=1; next cycle read set 3 with cmp_tag 0x2A5 -> one cycle later rtag way 2=0x2A5, hit_way_o=4'b0100, hit_o=1.
REQ-042 Write tag 0x011 to ways 0 and 1 of set 7 via wway_i=4'b0011; read with cmp_tag 0x011 -> hit_way_o=4'b0011, multi_hit_o=1, and it stays 1 afterwards.
REQ-043 Fill set 0 in all ways; pulse flush_req_i for 1 cycle concurrent with req_i -> req_i not granted; flush_ack_o pulses after 32 sweep cycles; a read of set 0 gives rvld_o=0.
REQ-044 Read accepted the cycle before flush_req_i -> that response is delivered with the old valid bits.
REQ-045 rst asserted at sweep count 10 of a FLUSH -> no flush_ack_o; INIT sweep restarts from 0.
